// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use bubble insertion, flush and hold
// Ports: clk, rst_n (sync, active-low); id_* decode-stage controls/data/indices in;
//        flush_i kills the entering instruction, hold_i freezes the stage;
//        ex_* registered copies out, ex_valid_o, load_use_stall_o (combinational),
//        bubble_cnt_o saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic            id_branch_i,
  input  logic            id_memread_i,
  input  logic            id_memtoreg_i,
  input  logic            id_memwrite_i,
  input  logic            id_alusrc_i,
  input  logic            id_regwrite_i,
  input  logic            id_jalr_jump_i,
  input  logic            id_jal_jump_i,
  input  logic [1:0]      id_regwrite_sel_i,
  input  logic [2:0]      id_aluop_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_funct7b5_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            ex_valid_o,
  output logic            ex_branch_o,
  output logic            ex_memread_o,
  output logic            ex_memtoreg_o,
  output logic            ex_memwrite_o,
  output logic            ex_alusrc_o,
  output logic            ex_regwrite_o,
  output logic            ex_jalr_jump_o,
  output logic            ex_jal_jump_o,
  output logic [1:0]      ex_regwrite_sel_o,
  output logic [2:0]      ex_aluop_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            load_use_stall_o,
  output logic [15:0]     bubble_cnt_o
);
  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       jalr_jump;
    logic       jal_jump;
    logic [1:0] regwrite_sel;
    logic [2:0] aluop;
  } ctrl_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
  } data_t;
  ctrl_t       ctrl_in, ctrl_d, ctrl_q;
  data_t       data_in, data_d, data_q;
  logic [15:0] cnt_d, cnt_q;
  logic        kill, load;
  assign ctrl_in = {id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i,
                    id_alusrc_i, id_regwrite_i, id_jalr_jump_i, id_jal_jump_i,
                    id_regwrite_sel_i, id_aluop_i};
  assign data_in = {id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
                    id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i};
  // Both source indices are compared for every opcode; a spurious stall is harmless.
  assign load_use_stall_o = rst_n & ctrl_q.valid & ctrl_q.memread & (|data_q.rd) & id_valid_i &
                            (data_q.rd == id_rs1_i | data_q.rd == id_rs2_i);
  // Flush beats hold; a load-use bubble only happens when the stage is not held.
  always_comb begin
    kill   = flush_i | (~hold_i & load_use_stall_o);
    load   = flush_i | ~hold_i;
    ctrl_d = load ? (kill ? '0 : ctrl_in) : ctrl_q;
    data_d = load ? data_in : data_q;
    cnt_d  = (kill && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end
  assign {ex_valid_o, ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o,
          ex_alusrc_o, ex_regwrite_o, ex_jalr_jump_o, ex_jal_jump_o,
          ex_regwrite_sel_o, ex_aluop_o} = ctrl_q;
  assign {ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
          ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o} = data_q;
  assign bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed bench with a stage-level reference model for id_ex_reg
module tb_id_ex_reg;
  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regwrite;
    logic        jalr_jump;
    logic        jal_jump;
    logic [1:0]  regwrite_sel;
    logic [2:0]  aluop;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
  } rec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic hold = 0;
  rec_t in = '0;
  rec_t dut_o;
  logic stall;
  logic [15:0] cnt;
  rec_t m = '0;
  int m_cnt = 0;
  bit m_known = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(in.valid), .id_branch_i(in.branch), .id_memread_i(in.memread),
    .id_memtoreg_i(in.memtoreg), .id_memwrite_i(in.memwrite), .id_alusrc_i(in.alusrc),
    .id_regwrite_i(in.regwrite), .id_jalr_jump_i(in.jalr_jump), .id_jal_jump_i(in.jal_jump),
    .id_regwrite_sel_i(in.regwrite_sel), .id_aluop_i(in.aluop),
    .id_pc_i(in.pc), .id_rs1_data_i(in.rs1_data), .id_rs2_data_i(in.rs2_data), .id_imm_i(in.imm),
    .id_rs1_i(in.rs1), .id_rs2_i(in.rs2), .id_rd_i(in.rd),
    .id_funct3_i(in.funct3), .id_funct7b5_i(in.funct7b5),
    .flush_i(flush), .hold_i(hold),
    .ex_valid_o(dut_o.valid), .ex_branch_o(dut_o.branch), .ex_memread_o(dut_o.memread),
    .ex_memtoreg_o(dut_o.memtoreg), .ex_memwrite_o(dut_o.memwrite), .ex_alusrc_o(dut_o.alusrc),
    .ex_regwrite_o(dut_o.regwrite), .ex_jalr_jump_o(dut_o.jalr_jump), .ex_jal_jump_o(dut_o.jal_jump),
    .ex_regwrite_sel_o(dut_o.regwrite_sel), .ex_aluop_o(dut_o.aluop),
    .ex_pc_o(dut_o.pc), .ex_rs1_data_o(dut_o.rs1_data), .ex_rs2_data_o(dut_o.rs2_data),
    .ex_imm_o(dut_o.imm), .ex_rs1_o(dut_o.rs1), .ex_rs2_o(dut_o.rs2), .ex_rd_o(dut_o.rd),
    .ex_funct3_o(dut_o.funct3), .ex_funct7b5_o(dut_o.funct7b5),
    .load_use_stall_o(stall), .bubble_cnt_o(cnt)
  );
  function automatic bit hazard(rec_t e, rec_t i, logic r);
    return r && e.valid && e.memread && e.rd != 0 && i.valid && (e.rd == i.rs1 || e.rd == i.rs2);
  endfunction
  function automatic rec_t bubble(rec_t r);
    rec_t b;
    b = r;
    b.valid = 0; b.branch = 0; b.memread = 0; b.memtoreg = 0; b.memwrite = 0;
    b.alusrc = 0; b.regwrite = 0; b.jalr_jump = 0; b.jal_jump = 0;
    b.regwrite_sel = 0; b.aluop = 0;
    return b;
  endfunction
  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      m <= '0;
      m_cnt <= 0;
      m_known <= 1;
    end else if (flush || (!hold && hazard(m, in, rst_n))) begin
      m <= bubble(in);
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (!hold) begin
      m <= in;
    end
  end
  always @(negedge clk) begin
    if (m_known) begin
      chk("model_ex_regs", dut_o, m);
      chk("model_stall", stall, hazard(m, in, rst_n));
      chk("model_count", cnt, m_cnt[15:0]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      flush = 1'($urandom);
      hold = 1'($urandom);
      tick();
      chk("reset_outputs", dut_o, 0);
      chk("reset_count", cnt, 0);
      chk("reset_stall", stall, 0);
    end
    rst_n = 1; flush = 0; hold = 0;
    in = '0; in.valid = 1; in.regwrite = 1; in.aluop = 3'b010; in.rs1_data = 5;
    in.rd = 3; in.rs1 = 1; in.rs2 = 2; in.pc = 32'h100;
    tick();
    chk("cap_valid", dut_o.valid, 1);
    chk("cap_regwrite", dut_o.regwrite, 1);
    chk("cap_aluop", dut_o.aluop, 3'b010);
    chk("cap_rs1_data", dut_o.rs1_data, 5);
    chk("cap_rd", dut_o.rd, 3);
    chk("cap_stall", stall, 0);
    in = '0; in.valid = 1; in.memread = 1; in.memtoreg = 1; in.regwrite = 1; in.alusrc = 1;
    in.rd = 5; in.rs1 = 2; in.pc = 32'h104;
    tick();
    in = '0; in.valid = 1; in.regwrite = 1; in.rs1 = 6; in.rs2 = 5; in.rd = 7; in.pc = 32'h108;
    #1 chk("lu_stall_on", stall, 1);
    tick();
    chk("lu_bubble_valid", dut_o.valid, 0);
    chk("lu_bubble_ctrl", {dut_o.regwrite, dut_o.memread, dut_o.memtoreg, dut_o.alusrc}, 0);
    chk("lu_bubble_rd", dut_o.rd, 7);
    chk("lu_count", cnt, 1);
    chk("lu_stall_off", stall, 0);
    tick();
    chk("lu_reissue_valid", dut_o.valid, 1);
    chk("lu_reissue_pc", dut_o.pc, 32'h108);
    in = '0; in.valid = 1; in.memread = 1; in.rd = 0; in.pc = 32'h10c;
    tick();
    in = '0; in.valid = 1; in.rs1 = 0; in.rs2 = 0; in.rd = 8; in.pc = 32'h110;
    #1 chk("rd0_stall", stall, 0);
    tick();
    chk("rd0_capture", dut_o.rd, 8);
    chk("rd0_count", cnt, 1);
    in = '0; in.valid = 1; in.regwrite = 1; in.rd = 9; in.branch = 1;
    flush = 1; hold = 1;
    tick();
    chk("fh_valid", dut_o.valid, 0);
    chk("fh_ctrl", {dut_o.regwrite, dut_o.branch}, 0);
    chk("fh_count", cnt, 2);
    flush = 0; hold = 0;
    in = '0; in.valid = 1; in.regwrite = 1; in.rd = 11; in.imm = 32'hdead;
    tick();
    hold = 1;
    in = '0; in.valid = 1; in.memwrite = 1; in.rd = 12;
    repeat (3) tick();
    chk("hold_rd", dut_o.rd, 11);
    chk("hold_imm", dut_o.imm, 32'hdead);
    chk("hold_valid", {dut_o.valid, dut_o.regwrite, dut_o.memwrite}, 3'b110);
    chk("hold_count", cnt, 2);
    hold = 0;
    in = '0; in.valid = 1; in.memread = 1; in.rd = 4;
    tick();
    hold = 1;
    in = '0; in.valid = 1; in.rs1 = 4; in.rd = 13;
    tick();
    chk("hold_lu_stall", stall, 1);
    chk("hold_lu_memread", dut_o.memread, 1);
    chk("hold_lu_count", cnt, 2);
    rst_n = 0; hold = 0;
    tick();
    chk("rst_mid_count", cnt, 0);
    chk("rst_mid_stall", stall, 0);
    rst_n = 1;
    flush = 1;
    repeat (65534) @(posedge clk);
    #2 chk("sat_fffe", cnt, 16'hFFFE);
    repeat (2) tick();
    chk("sat_ffff", cnt, 16'hFFFF);
    tick();
    chk("sat_hold", cnt, 16'hFFFF);
    flush = 0;
    @(negedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
